// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester-side request/response bus of the shared multiplier arbiter
// master: the requester bank; slave: the arbiter.
interface mult_share_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_err
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one sequential multiplier between NUM_REQ requesters
// Sequences start/done, routes the product to the granted requester, and times out a silent multiplier.
module mult_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_done,
  output logic                 busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] pick_oh;

  // Round-robin scan starts just after the last served requester.
  always_comb begin
    int idx;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_found && bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
    pick_oh = pick_found ? (NUM_REQ'(1) << pick_idx) : '0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          mul_a_d = bus.req_a[pick_idx*WIDTH +: WIDTH];
          mul_b_d = bus.req_b[pick_idx*WIDTH +: WIDTH];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done seen on the first WAIT cycle may be left over from the previous operation.
        if (mul_done && (cnt_q != '0)) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready[gnt_q]) begin
          ptr_d   = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready   = ((state_q == S_IDLE) && rst_n) ? pick_oh : '0;
  assign bus.rsp_valid   = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err     = err_q;
  assign mul_start       = (state_q == S_ISSUE);
  assign mul_a           = mul_a_q;
  assign mul_b           = mul_b_q;
  assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter with a behavioural multiplier stub
// Expected responses are queued as stimulus is issued and compared against responses captured on accept.
module tb_mult_share_arbiter;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [NUM_REQ-1:0] v;
    logic [2*WIDTH-1:0] p;
    logic               e;
  } rsp_t;

  logic               clk;
  logic               rst_n;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_done;
  logic               busy;
  logic               dead;
  int                 stub_cnt;

  mult_share_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  mult_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequential multiplier stand-in: done pulses three cycles after start unless 'dead'.
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_cnt    <= 0;
      mul_done    <= 1'b0;
      mul_product <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) stub_cnt <= 3;
      else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !dead) begin
          mul_done    <= 1'b1;
          mul_product <= mul_a * mul_b;
        end
      end
    end
  end

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   start_cnt = 0;
  int   pass_cnt  = 0;
  int   tot_cnt   = 0;
  int   rem[NUM_REQ];

  always @(negedge clk) begin
    if (rst_n && |(bus.rsp_valid & bus.rsp_ready))
      obs_q.push_back('{v: bus.rsp_valid, p: bus.rsp_product, e: bus.rsp_err});
    if (mul_start) start_cnt++;
  end

  task automatic set_ops(input int i, input int a, input int b);
    bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Requester model: each requester keeps req_valid up until rem[i] handshakes have completed.
  task automatic drive_until(input int n_obs, input int budget, output bit timed_out);
    logic [NUM_REQ-1:0] fire;
    timed_out = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (rem[i] > 0) bus.req_valid[i] = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      fire = bus.req_valid & bus.req_ready;
      if (obs_q.size() >= n_obs) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i]) begin
          rem[i]--;
          if (rem[i] == 0) bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    tot_cnt++;
    if (bus.req_ready !== '0) $display("FAIL rst_req_ready: got %b required 0000", bus.req_ready);
    else pass_cnt++;
    tot_cnt++;
    if ({bus.rsp_valid, bus.rsp_product, bus.rsp_err} !== '0)
      $display("FAIL rst_rsp: got v=%b p=%0d e=%b required all zero", bus.rsp_valid, bus.rsp_product, bus.rsp_err);
    else pass_cnt++;
    tot_cnt++;
    if ({mul_start, mul_a, mul_b, busy} !== '0)
      $display("FAIL rst_mul: got start=%b a=%0d b=%0d busy=%b required all zero", mul_start, mul_a, mul_b, busy);
    else pass_cnt++;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit   to;
    int   s0;
    rsp_t o, ex;
    s0 = start_cnt;
    set_ops(0, 5, 3);
    rem[0] = 1;
    exp_q.push_back('{v: 4'b0001, p: 16'd15, e: 1'b0});
    drive_until(1, 100, to);
    tot_cnt++;
    if (to) $display("FAIL single_timeout: got timeout required response"); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL single_rsp: got none required v=%b p=%0d e=%b", ex.v, ex.p, ex.e);
      else begin
        o = obs_q.pop_front();
        if (o !== ex) $display("FAIL single_rsp: got v=%b p=%0d e=%b required v=%b p=%0d e=%b", o.v, o.p, o.e, ex.v, ex.p, ex.e);
        else pass_cnt++;
      end
    end
    tot_cnt++;
    if (start_cnt - s0 != 1) $display("FAIL single_start_cycles: got %0d required 1", start_cnt - s0); else pass_cnt++;
    @(negedge clk); #1;
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL single_busy_after: got %b required 0", busy); else pass_cnt++;
  endtask

  task automatic test_all_four();
    bit   to;
    rsp_t o, ex;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_ops(i, (i + 1) * 10, (i + 1) * 10);
      rem[i] = 1;
      exp_q.push_back('{v: NUM_REQ'(1) << i, p: 16'((i + 1) * (i + 1) * 100), e: 1'b0});
    end
    drive_until(4, 400, to);
    tot_cnt++;
    if (to) $display("FAIL four_timeout: got timeout required 4 responses"); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL four_rsp: got none required v=%b p=%0d e=%b", ex.v, ex.p, ex.e);
      else begin
        o = obs_q.pop_front();
        if (o !== ex) $display("FAIL four_rsp: got v=%b p=%0d e=%b required v=%b p=%0d e=%b", o.v, o.p, o.e, ex.v, ex.p, ex.e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_alternate();
    bit   to;
    rsp_t o, ex;
    set_ops(1, 15, 10);
    set_ops(3, 15, 10);
    rem[1] = 2;
    rem[3] = 2;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{v: (k % 2 == 0) ? 4'b0010 : 4'b1000, p: 16'd150, e: 1'b0});
    drive_until(4, 400, to);
    tot_cnt++;
    if (to) $display("FAIL alt_timeout: got timeout required 4 responses"); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL alt_rsp: got none required v=%b p=%0d e=%b", ex.v, ex.p, ex.e);
      else begin
        o = obs_q.pop_front();
        if (o !== ex) $display("FAIL alt_rsp: got v=%b p=%0d e=%b required v=%b p=%0d e=%b", o.v, o.p, o.e, ex.v, ex.p, ex.e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit   to;
    rsp_t o, ex;
    set_ops(2, 255, 255);
    set_ops(0, 7, 9);
    exp_q.push_back('{v: 4'b0100, p: 16'd65025, e: 1'b0});
    exp_q.push_back('{v: 4'b0001, p: 16'd63, e: 1'b0});
    bus.rsp_ready = 4'b1011;
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (bus.req_ready[2]) break;
    end
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != '0) break;
    end
    for (int k = 0; k < 5; k++) begin
      tot_cnt++;
      if (bus.rsp_valid !== 4'b0100) $display("FAIL bp_rsp_valid: got %b required 0100", bus.rsp_valid); else pass_cnt++;
      tot_cnt++;
      if (bus.rsp_product !== 16'd65025) $display("FAIL bp_product: got %0d required 65025", bus.rsp_product); else pass_cnt++;
      tot_cnt++;
      if (bus.req_ready !== 4'b0000) $display("FAIL bp_req_ready: got %b required 0000", bus.req_ready); else pass_cnt++;
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 4'b1111;
    @(negedge clk); #1;
    @(negedge clk); #1;
    tot_cnt++;
    if (bus.req_ready !== 4'b0001) $display("FAIL bp_resume: got %b required 0001", bus.req_ready); else pass_cnt++;
    @(posedge clk); #1;
    bus.req_valid = '0;
    drive_until(2, 100, to);
    tot_cnt++;
    if (to) $display("FAIL bp_timeout: got timeout required 2 responses"); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL bp_rsp: got none required v=%b p=%0d e=%b", ex.v, ex.p, ex.e);
      else begin
        o = obs_q.pop_front();
        if (o !== ex) $display("FAIL bp_rsp: got v=%b p=%0d e=%b required v=%b p=%0d e=%b", o.v, o.p, o.e, ex.v, ex.p, ex.e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_timeout();
    bit   to;
    int   n;
    rsp_t o, ex;
    dead = 1'b1;
    set_ops(1, 9, 9);
    exp_q.push_back('{v: 4'b0010, p: 16'd0, e: 1'b1});
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (mul_start) break;
    end
    bus.req_valid = '0;
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      n++;
      if (bus.rsp_valid != '0) break;
    end
    tot_cnt++;
    if (n != TIMEOUT + 1) $display("FAIL to_latency: got %0d required %0d", n, TIMEOUT + 1); else pass_cnt++;
    drive_until(1, 20, to);
    dead = 1'b0;
    set_ops(1, 10, 0);
    rem[1] = 1;
    exp_q.push_back('{v: 4'b0010, p: 16'd0, e: 1'b0});
    drive_until(2, 100, to);
    tot_cnt++;
    if (to) $display("FAIL to_timeout: got timeout required 2 responses"); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL to_rsp: got none required v=%b p=%0d e=%b", ex.v, ex.p, ex.e);
      else begin
        o = obs_q.pop_front();
        if (o !== ex) $display("FAIL to_rsp: got v=%b p=%0d e=%b required v=%b p=%0d e=%b", o.v, o.p, o.e, ex.v, ex.p, ex.e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit   to;
    int   snap;
    rsp_t o, ex;
    set_ops(0, 3, 4);
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (mul_start) break;
    end
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk); #1;
    tot_cnt++;
    if ({bus.req_ready, bus.rsp_valid, busy, mul_start} !== '0)
      $display("FAIL midrst_ctrl: got rdy=%b v=%b busy=%b start=%b required all zero", bus.req_ready, bus.rsp_valid, busy, mul_start);
    else pass_cnt++;
    tot_cnt++;
    if ({mul_a, mul_b, bus.rsp_product, bus.rsp_err} !== '0)
      $display("FAIL midrst_data: got a=%0d b=%0d p=%0d e=%b required all zero", mul_a, mul_b, bus.rsp_product, bus.rsp_err);
    else pass_cnt++;
    snap = obs_q.size();
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tot_cnt++;
    if (obs_q.size() != snap) $display("FAIL midrst_no_rsp: got %0d responses required %0d", obs_q.size(), snap); else pass_cnt++;
    set_ops(0, 255, 255);
    rem[0] = 1;
    exp_q.push_back('{v: 4'b0001, p: 16'd65025, e: 1'b0});
    drive_until(snap + 1, 100, to);
    tot_cnt++;
    if (to) $display("FAIL midrst_timeout: got timeout required response"); else pass_cnt++;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front(); tot_cnt++;
      if (obs_q.size() == 0) $display("FAIL midrst_rsp: got none required v=%b p=%0d e=%b", ex.v, ex.p, ex.e);
      else begin
        o = obs_q.pop_front();
        if (o !== ex) $display("FAIL midrst_rsp: got v=%b p=%0d e=%b required v=%b p=%0d e=%b", o.v, o.p, o.e, ex.v, ex.p, ex.e);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    dead          = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    tot_cnt++;
    if (obs_q.size() != 0) $display("FAIL extra_rsp: got %0d unexpected responses required 0", obs_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
